// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the sequential RV32M multiply/divide unit:
// width, funct3 opcodes, FSM state type and operand signedness helpers.
package mdu_seq_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } mdu_state_t;

   // rs1 is signed for every op except MULHU and the unsigned divides.
   function automatic logic a_is_signed(input logic [2:0] f3);
      return f3[2] ? ~f3[0] : (f3 != F3_MULHU);
   endfunction

   // rs2 is signed only for MUL, MULH, DIV and REM.
   function automatic logic b_is_signed(input logic [2:0] f3);
      return f3[2] ? ~f3[0] : ~f3[1];
   endfunction

endpackage

// File: rtl/mdu_seq_fixup.sv
// Two's-complement sign restoration and result selection applied to the
// magnitude-domain accumulator once the last radix-2 step is known.
module mdu_seq_fixup
   import mdu_seq_pkg::*;
#(
   parameter int XLEN = mdu_seq_pkg::XLEN
) (
   input  logic [2:0]        funct3,
   input  logic [2*XLEN-1:0] acc,
   input  logic              neg_a,
   input  logic              neg_b,
   input  logic              b_zero,
   output logic [XLEN-1:0]   result
);

   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo;
   logic [XLEN-1:0]   rem;
   logic              neg_res;

   always_comb begin
      neg_res = neg_a ^ neg_b;
      prod    = neg_res ? -acc : acc;
      quo     = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      // Remainder follows the dividend, which also yields rem = src_a on /0.
      rem     = neg_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      result  = prod[XLEN-1:0];
      case (funct3)
         F3_MUL:                       result = prod[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: result = prod[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:              result = b_zero ? '1 : quo;
         F3_REM, F3_REMU:              result = rem;
         default:                      result = rem;
      endcase
   end

endmodule

// File: rtl/mdu_seq.sv
// Sequential RV32M multiply/divide unit: one radix-2 shift-add or restoring
// subtract-shift step per cycle on operand magnitudes, fixed XLEN+1 latency.
module mdu_seq
   import mdu_seq_pkg::*;
#(
   parameter int XLEN = mdu_seq_pkg::XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic            stall,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN) + 1;

   mdu_state_t        state_reg, state_next;
   logic [CW-1:0]     count_reg;
   logic [2*XLEN-1:0] acc_reg, acc_step;
   logic [XLEN-1:0]   op_a_reg, op_b_reg;
   logic [2:0]        f3_reg;
   logic              neg_a_reg, neg_b_reg, b_zero_reg;
   logic              done_reg;
   logic [XLEN-1:0]   result_reg, result_fix;

   logic              accept, step_en, last_step;
   logic              neg_a_in, neg_b_in;
   logic [XLEN-1:0]   mag_a_in, mag_b_in;
   logic [XLEN:0]     mul_sum, div_rem, div_diff;
   logic              div_ge;

   assign accept    = (state_reg == IDLE) & start & ~flush;
   assign step_en   = (state_reg == CALC) & ~flush;
   assign last_step = step_en & (count_reg == CW'(1));

   assign busy   = (state_reg != IDLE);
   assign done   = done_reg;
   assign result = result_reg;
   // Gated by reset so the execute stage is never held while the unit is in reset.
   assign stall  = rst & (((state_reg == IDLE) & start & ~flush) | (state_reg == CALC));

   always_comb begin
      neg_a_in = a_is_signed(funct3) & src_a[XLEN-1];
      neg_b_in = b_is_signed(funct3) & src_b[XLEN-1];
      mag_a_in = neg_a_in ? -src_a : src_a;
      mag_b_in = neg_b_in ? -src_b : src_b;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      if (flush) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (count_reg == CW'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // Multiply keeps the multiplicand in op_a and shifts the multiplier out of op_b;
   // divide shifts dividend bits out of op_a into the remainder half of acc.
   always_comb begin
      mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (op_b_reg[0] ? {1'b0, op_a_reg} : '0);
      div_rem  = {acc_reg[2*XLEN-1:XLEN], op_a_reg[XLEN-1]};
      div_diff = div_rem - {1'b0, op_b_reg};
      div_ge   = ~div_diff[XLEN];
      if (f3_reg[2]) begin
         acc_step = {(div_ge ? div_diff[XLEN-1:0] : div_rem[XLEN-1:0]),
                     acc_reg[XLEN-2:0], div_ge};
      end else begin
         acc_step = {mul_sum, acc_reg[XLEN-1:1]};
      end
   end

   mdu_seq_fixup #(
      .XLEN(XLEN)
   ) u_fixup (
      .funct3 (f3_reg),
      .acc    (acc_step),
      .neg_a  (neg_a_reg),
      .neg_b  (neg_b_reg),
      .b_zero (b_zero_reg),
      .result (result_fix)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_reg  <= '0;
         acc_reg    <= '0;
         op_a_reg   <= '0;
         op_b_reg   <= '0;
         f3_reg     <= '0;
         neg_a_reg  <= 1'b0;
         neg_b_reg  <= 1'b0;
         b_zero_reg <= 1'b0;
         done_reg   <= 1'b0;
         result_reg <= '0;
      end else begin
         done_reg <= last_step;
         if (accept) begin
            f3_reg     <= funct3;
            neg_a_reg  <= neg_a_in;
            neg_b_reg  <= neg_b_in;
            b_zero_reg <= (src_b == '0);
            op_a_reg   <= mag_a_in;
            op_b_reg   <= mag_b_in;
            acc_reg    <= '0;
            count_reg  <= CW'(XLEN);
         end else if (step_en) begin
            acc_reg   <= acc_step;
            count_reg <= count_reg - CW'(1);
            if (f3_reg[2]) begin
               op_a_reg <= {op_a_reg[XLEN-2:0], 1'b0};
            end else begin
               op_b_reg <= {1'b0, op_b_reg[XLEN-1:1]};
            end
            // The signed result is latched on the edge that enters DONE.
            if (last_step) begin
               result_reg <= result_fix;
            end
         end
      end
   end

endmodule
